// File: rtl/vc4_mapper_pkg.sv
// vc4_mapper_pkg: shared constants, widths and state type for the C4 -> VC4 mapper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vc4_mapper_pkg;

  localparam int C4_ROWS     = 9;
  localparam int C4_COLS     = 260;
  localparam int VC4_COLS    = 261;
  localparam int VC4_POH_COL = 0;

  localparam int POH_J1_ROW  = 0;
  localparam int POH_B3_ROW  = 1;
  localparam int POH_C2_ROW  = 2;

  localparam int ROW_W = 4;
  localparam int COL_W = 9;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(C4_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(VC4_COLS - 1);
  localparam logic [COL_W-1:0] POH_COL  = COL_W'(VC4_POH_COL);

  typedef enum logic {HUNT, RUN} vc4_map_state_t;

endpackage

// File: rtl/vc4_poh_gen.sv
// vc4_poh_gen: selects the POH byte for a VC4 row and (optionally) computes B3.
// Latency: POH byte is combinational in row; B3 register updates on the last frame byte transfer.
// Backpressure: none; only counts bytes actually transferred downstream.
// Ports: clk/rst_n; row (current VC4 row); xfer + xfer_byte/sof/eof describe a downstream
// transfer; clear (HUNT entry) discards partial parity; poh = byte for column 0.
// Macro VC4_B3_CALC_EN: when defined, row 1 carries the BIP-8 of the previous frame;
// otherwise row 1 carries POH_FILL and no parity state exists.
module vc4_poh_gen
  import vc4_mapper_pkg::*;
#(
  parameter logic [7:0] J1_BYTE  = 8'h01,
  parameter logic [7:0] C2_BYTE  = 8'h02,
  parameter logic [7:0] POH_FILL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROW_W-1:0] row,
  input  logic             xfer,
  input  logic [7:0]       xfer_byte,
  input  logic             xfer_sof,
  input  logic             xfer_eof,
  input  logic             clear,
  output logic [7:0]       poh
);

  logic [7:0] b3_byte;

`ifdef VC4_B3_CALC_EN
  logic [7:0] acc;
  logic [7:0] b3;
  logic       b3_ok;

  // J1 transfer restarts the accumulator, so a stale byte of an aborted frame
  // that drains after relock never leaks into the next parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 8'h00;
      b3    <= 8'h00;
      b3_ok <= 1'b0;
    end else if (clear) begin
      acc   <= 8'h00;
      b3_ok <= 1'b0;
    end else if (xfer) begin
      if (xfer_eof) begin
        b3    <= acc ^ xfer_byte;
        acc   <= 8'h00;
        b3_ok <= 1'b1;
      end else if (xfer_sof) begin
        acc <= xfer_byte;
      end else begin
        acc <= acc ^ xfer_byte;
      end
    end
  end

  assign b3_byte = b3_ok ? b3 : 8'h00;
`else
  logic unused_b3;
  assign unused_b3 = ^{clk, rst_n, xfer, xfer_byte, xfer_sof, xfer_eof, clear};
  assign b3_byte   = POH_FILL;
`endif

  always_comb begin
    poh = POH_FILL;
    if (row == ROW_W'(POH_J1_ROW))      poh = J1_BYTE;
    else if (row == ROW_W'(POH_B3_ROW)) poh = b3_byte;
    else if (row == ROW_W'(POH_C2_ROW)) poh = C2_BYTE;
  end

endmodule

// File: rtl/vc4_mapper.sv
// vc4_mapper: maps a byte-serial C4 (9x260) into a VC4 (9x261) by inserting the POH column.
// Latency: sof byte accepted at edge k -> J1 on vc4_data after k+1, sof byte after k+2.
// Backpressure: output holds while valid&~ready; input stalls only when the one-entry buffer is full.
// Ports: clk, rst_n; c4_data/c4_sof/c4_valid/c4_ready input stream; vc4_data/vc4_sof/vc4_sor/
// vc4_valid/vc4_ready output stream; locked (in RUN); frame_err (1-cycle alignment-loss pulse).
// Macro VC4_B3_CALC_EN enables the B3 parity carried in row 1 (see vc4_poh_gen).
module vc4_mapper
  import vc4_mapper_pkg::*;
#(
  parameter logic [7:0] J1_BYTE  = 8'h01,
  parameter logic [7:0] C2_BYTE  = 8'h02,
  parameter logic [7:0] POH_FILL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] c4_data,
  input  logic       c4_sof,
  input  logic       c4_valid,
  output logic       c4_ready,
  output logic [7:0] vc4_data,
  output logic       vc4_sof,
  output logic       vc4_sor,
  output logic       vc4_valid,
  input  logic       vc4_ready,
  output logic       locked,
  output logic       frame_err
);

  vc4_map_state_t   state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [COL_W-1:0] col, col_nxt;

  logic       ibuf_valid, ibuf_sof, ibuf_pop;
  logic [7:0] ibuf_data;

  logic       adv, xfer;
  logic       ld, ld_sof, ld_sor, ld_eof;
  logic [7:0] ld_data;
  logic       err;
  logic       vc4_eof;
  logic [7:0] poh_byte;
  logic       exp_sof;

  assign adv      = ~vc4_valid | vc4_ready;
  assign xfer     = vc4_valid & vc4_ready;
  assign c4_ready = ~ibuf_valid | ibuf_pop;
  assign locked   = (state == RUN);
  assign exp_sof  = (row == '0) && (col == COL_W'(1));

  // row is forced to 0 whenever HUNT is entered, so it is valid for J1 selection in HUNT too.
  vc4_poh_gen #(
    .J1_BYTE  (J1_BYTE),
    .C2_BYTE  (C2_BYTE),
    .POH_FILL (POH_FILL)
  ) u_poh (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .xfer      (xfer),
    .xfer_byte (vc4_data),
    .xfer_sof  (vc4_sof),
    .xfer_eof  (vc4_eof),
    .clear     (err),
    .poh       (poh_byte)
  );

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    ibuf_pop  = 1'b0;
    ld        = 1'b0;
    ld_data   = ibuf_data;
    ld_sof    = 1'b0;
    ld_sor    = 1'b0;
    ld_eof    = 1'b0;
    err       = 1'b0;

    unique case (state)
      HUNT: begin
        if (ibuf_valid) begin
          if (!ibuf_sof) begin
            ibuf_pop = 1'b1;
          end else begin
            // Relock: the row 0 / col 0 step is taken in this same cycle so J1
            // follows the sof byte's arrival in ibuf by one edge.
            state_nxt = RUN;
            row_nxt   = '0;
            col_nxt   = '0;
            if (adv) begin
              ld      = 1'b1;
              ld_data = poh_byte;
              ld_sof  = 1'b1;
              ld_sor  = 1'b1;
              col_nxt = COL_W'(1);
            end
          end
        end
      end
      RUN: begin
        if (adv) begin
          if (col == POH_COL) begin
            ld      = 1'b1;
            ld_data = poh_byte;
            ld_sof  = (row == '0);
            ld_sor  = 1'b1;
            col_nxt = COL_W'(1);
          end else if (ibuf_valid) begin
            if (ibuf_sof == exp_sof) begin
              ibuf_pop = 1'b1;
              ld       = 1'b1;
              ld_eof   = (row == LAST_ROW) && (col == LAST_COL);
              if (col == LAST_COL) begin
                col_nxt = '0;
                row_nxt = (row == LAST_ROW) ? '0 : row + 1'b1;
              end else begin
                col_nxt = col + 1'b1;
              end
            end else begin
              // A misplaced sof is kept so HUNT can relock on it next cycle.
              err       = 1'b1;
              state_nxt = HUNT;
              row_nxt   = '0;
              col_nxt   = '0;
              ibuf_pop  = ~ibuf_sof;
            end
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibuf_valid <= 1'b0;
      ibuf_data  <= 8'h00;
      ibuf_sof   <= 1'b0;
    end else if (c4_valid && c4_ready) begin
      ibuf_valid <= 1'b1;
      ibuf_data  <= c4_data;
      ibuf_sof   <= c4_sof;
    end else if (ibuf_pop) begin
      ibuf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc4_data  <= 8'h00;
      vc4_sof   <= 1'b0;
      vc4_sor   <= 1'b0;
      vc4_valid <= 1'b0;
      vc4_eof   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (adv) begin
        vc4_valid <= ld;
        vc4_sof   <= ld & ld_sof;
        vc4_sor   <= ld & ld_sor;
        vc4_eof   <= ld & ld_eof;
        if (ld) vc4_data <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_vc4_mapper.sv
// tb_vc4_mapper: directed self-checking bench for vc4_mapper.
// Drives inputs and samples outputs 1 time unit after each falling clock edge.
// Expected streams are built from hand-derived frame layouts (payload = index & 8'hFF).
module tb_vc4_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] c4_data;
  logic       c4_sof, c4_valid, c4_ready;
  logic [7:0] vc4_data;
  logic       vc4_sof, vc4_sor, vc4_valid, vc4_ready;
  logic       locked, frame_err;

  always #5 clk = ~clk;

  vc4_mapper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c4_data   (c4_data),
    .c4_sof    (c4_sof),
    .c4_valid  (c4_valid),
    .c4_ready  (c4_ready),
    .vc4_data  (vc4_data),
    .vc4_sof   (vc4_sof),
    .vc4_sor   (vc4_sor),
    .vc4_valid (vc4_valid),
    .vc4_ready (vc4_ready),
    .locked    (locked),
    .frame_err (frame_err)
  );

  // Frame 1 parity: POH 01^00^02 = 03, payload k&FF over k=0..2339 XORs to 00.
`ifdef VC4_B3_CALC_EN
  localparam logic [7:0] B3_F1 = 8'h03;
`else
  localparam logic [7:0] B3_F1 = 8'h00;
`endif
  localparam int FRAME_OUT = 2349;
  localparam int FRAME_IN  = 2340;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] in_dat[$];
  bit         in_sof[$];
  logic [7:0] exp_dat[$];
  bit         exp_sof[$], exp_sor[$];
  logic [7:0] out_dat[$];
  bit         out_sof[$], out_sor[$];

  int  in_idx, cyc, sof_cyc, j1_cyc, stall_bad, locked_early, err_pulses;
  bit  sof_acc, rdy_rand, prev_stall;
  logic [9:0] prev_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] poh_of(input int r, input logic [7:0] b3);
    case (r)
      0:       return 8'h01;
      1:       return b3;
      2:       return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] out_at(input int i);
    if (i < out_dat.size()) return out_dat[i];
    return 8'hxx;
  endfunction

  // Queue n_in input bytes of a frame and the VC4 bytes they should produce.
  task automatic add_frame(input logic [7:0] b3, input int n_in);
    for (int k = 0; k < n_in; k++) begin
      in_dat.push_back(8'(k));
      in_sof.push_back(k == 0);
    end
    for (int r = 0; r < 9; r++) begin
      if (r * 260 < n_in) begin
        exp_dat.push_back(poh_of(r, b3));
        exp_sof.push_back(r == 0);
        exp_sor.push_back(1'b1);
      end
      for (int c = 0; c < 260; c++) begin
        if (r * 260 + c < n_in) begin
          exp_dat.push_back(8'(r * 260 + c));
          exp_sof.push_back(1'b0);
          exp_sor.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c4_valid = 1'b0; c4_data = 8'h00; c4_sof = 1'b0; vc4_ready = 1'b1;
    in_dat.delete(); in_sof.delete();
    exp_dat.delete(); exp_sof.delete(); exp_sor.delete();
    out_dat.delete(); out_sof.delete(); out_sor.delete();
    in_idx = 0; cyc = 0; sof_cyc = -1; j1_cyc = -1; stall_bad = 0;
    locked_early = 0; err_pulses = 0; sof_acc = 0; prev_stall = 0; rdy_rand = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    vc4_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (in_idx < in_dat.size()) begin
      c4_valid = 1'b1; c4_data = in_dat[in_idx]; c4_sof = in_sof[in_idx];
    end else begin
      c4_valid = 1'b0; c4_data = 8'h00; c4_sof = 1'b0;
    end
    #1;
    if (prev_stall && ({vc4_valid, vc4_sof, vc4_data} != {1'b1, prev_out[8:0]})) stall_bad++;
    prev_stall = vc4_valid & ~vc4_ready;
    prev_out   = {vc4_sor, vc4_sof, vc4_data};
    if (locked && !sof_acc) locked_early++;
    if (frame_err) err_pulses++;
    if (vc4_valid && vc4_ready) begin
      out_dat.push_back(vc4_data);
      out_sof.push_back(vc4_sof);
      out_sor.push_back(vc4_sor);
      if (j1_cyc < 0) j1_cyc = cyc;
    end
    if (c4_valid && c4_ready) begin
      if (c4_sof && !sof_acc) begin
        sof_acc = 1'b1;
        sof_cyc = cyc;
      end
      in_idx++;
    end
    cyc++;
  endtask

  task automatic run_until(input int n_out, input int budget);
    for (int i = 0; i < budget && out_dat.size() < n_out; i++) step();
  endtask

  task automatic cmp_stream(input string tag);
    int bad = 0;
    for (int i = 0; i < exp_dat.size(); i++) begin
      if (i >= out_dat.size()) bad++;
      else if (out_dat[i] !== exp_dat[i] || out_sof[i] !== exp_sof[i] || out_sor[i] !== exp_sor[i]) bad++;
    end
    check_eq({tag, "_len"}, out_dat.size() >= exp_dat.size(), 1);
    check_eq({tag, "_bytes"}, bad, 0);
  endtask

  initial begin
    int nsof, nsor;

    // 1: reset values and idle after release
    rst_n = 1'b0; c4_valid = 1'b0; c4_data = 8'h00; c4_sof = 1'b0; vc4_ready = 1'b1;
    #1;
    check_eq("rst_outs", {vc4_data, vc4_valid, vc4_sof, vc4_sor, locked, frame_err}, 13'h0);
    do_reset();
    repeat (5) step();
    check_eq("idle_flags", {vc4_valid, locked, frame_err, c4_ready}, 4'b0001);

    // 2: single frame, ready always high
    do_reset();
    add_frame(8'h00, FRAME_IN);
    run_until(FRAME_OUT, 4000);
    cmp_stream("frame1");
    for (int r = 0; r < 9; r++) check_eq($sformatf("poh_r%0d", r), out_at(r * 261), poh_of(r, 8'h00));
    nsof = 0; nsor = 0;
    for (int i = 0; i < FRAME_OUT && i < out_dat.size(); i++) begin
      nsof += out_sof[i];
      nsor += out_sor[i];
    end
    check_eq("sof_count", nsof, 1);
    check_eq("sor_count", nsor, 9);
    check_eq("lat_j1", j1_cyc - sof_cyc, 2);

    // 3: two frames, B3 of frame 1 in frame 2 row 1
    do_reset();
    add_frame(8'h00, FRAME_IN);
    add_frame(B3_F1, FRAME_IN);
    run_until(2 * FRAME_OUT, 8000);
    cmp_stream("two_frames");
    check_eq("b3_f1", out_at(261), 8'h00);
    check_eq("b3_f2", out_at(FRAME_OUT + 261), B3_F1);

    // 4: random downstream backpressure
    do_reset();
    rdy_rand = 1'b1;
    add_frame(8'h00, FRAME_IN);
    run_until(FRAME_OUT, 12000);
    cmp_stream("rand_rdy");
    check_eq("stall_hold", stall_bad, 0);

    // 5: five junk bytes before the first sof
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_dat.push_back(8'hA0 + 8'(i));
      in_sof.push_back(1'b0);
    end
    add_frame(8'h00, FRAME_IN);
    run_until(FRAME_OUT, 4000);
    cmp_stream("hunt_drop");
    check_eq("hunt_first_j1", {out_sof.size() > 0 ? out_sof[0] : 1'b0, out_at(0)}, 9'h101);
    check_eq("locked_early", locked_early, 0);

    // 6: sof at row 3 / col 10 of a running frame, then two clean frames
    do_reset();
    add_frame(8'h00, 3 * 260 + 10);
    add_frame(8'h00, FRAME_IN);
    add_frame(B3_F1, FRAME_IN);
    run_until(794 + 2 * FRAME_OUT, 9000);
    repeat (3) step();
    cmp_stream("realign");
    check_eq("err_pulses", err_pulses, 1);
    check_eq("relock_j1", {794 < out_sof.size() ? out_sof[794] : 1'b0, out_at(794)}, 9'h101);
    check_eq("relock_b3", out_at(794 + 261), 8'h00);

    // 1 (cont.): asynchronous reset in the middle of row 4
    do_reset();
    add_frame(8'h00, FRAME_IN);
    for (int i = 0; i < 4 * 261 + 100; i++) step();
    check_eq("pre_rst_locked", locked, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_flags", {vc4_valid, vc4_sof, vc4_sor, locked, frame_err, c4_ready}, 6'b000001);
    check_eq("async_rst_data", vc4_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
